sp_stream_out: RTL and testbench
================================

SP_STREAM_OUT -- requirements
Module: sp_stream_out

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, element width in bits.
REQ-002 BUS_WIDTH, 64, bus/row width; MAX_DIM = BUS_WIDTH/DATA_WIDTH; ENTRIES = MAX_DIM*MAX_DIM.
REQ-003 SP_NTARGETS, 4, number of scratchpad targets; AW = 2*clog2(MAX_DIM).
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  1  dump request, sampled only in IDLE.
REQ-007 target_i  in  2  scratchpad target to dump.
REQ-008 sp_rd_en_o  out  1  scratchpad read strobe.
REQ-009 sp_rd_target_o  out  2  read target (latched target_i).
REQ-010 sp_rd_addr_o  out  AW  read row address.
REQ-011 sp_rd_data_i  in  BUS_WIDTH  read data, valid combinationally in the cycle sp_rd_en_o=1.
REQ-012 m_valid_o / m_ready_i / m_data_o(BUS_WIDTH) / m_index_o(AW) / m_last_o(1): output stream; beat transfers when m_valid_o & m_ready_i.
REQ-013 busy_o  out  1  high in every non-IDLE state; done_o  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-015 IDLE->READ on start_i=1; target_i latched at that edge; read address counter cleared to 0.
REQ-016 start_i while not IDLE SHALL be ignored with no effect on the running dump.
REQ-017 A 2-entry FIFO SHALL buffer {data, index}; push at the edge ending a cycle with sp_rd_en_o=1.
REQ-018 In READ, sp_rd_en_o SHALL be 1 iff FIFO count<2 or a pop occurs that cycle.
REQ-019 Address counter SHALL increment after each issued read; read issued with address ENTRIES-1 moves READ->DRAIN; exactly ENTRIES reads per dump, addresses 0..ENTRIES-1 in order, no wrap.
REQ-020 DRAIN->DONE when FIFO empty, or count=1 and a pop occurs that cycle.
REQ-021 DONE SHALL assert done_o for exactly one cycle, then ->IDLE.
REQ-022 m_valid_o = FIFO non-empty; m_data_o/m_index_o = FIFO head; m_data_o and m_index_o SHALL be 0 when m_valid_o=0.
REQ-023 m_last_o = m_valid_o & (m_index_o == ENTRIES-1).
REQ-024 With m_valid_o=1 and m_ready_i=0, m_data_o/m_index_o/m_last_o SHALL hold stable.
REQ-025 Simultaneous push and pop SHALL keep count unchanged, no data loss or reordering.
REQ-026 sp_rd_addr_o and sp_rd_target_o SHALL be 0 when sp_rd_en_o=0.
REQ-027 Latency: start_i in cycle 0 -> first read cycle 1 -> first m_valid_o cycle 2; with m_ready_i=1 throughout, one beat/cycle, beats cycles 2..ENTRIES+1, done_o cycle ENTRIES+2.

Reset
REQ-028 rst_ni=0 at a rising edge SHALL force IDLE, FIFO empty, counters 0, latched target 0, regardless of state (including mid-dump).
REQ-029 Reset values: busy_o=0, done_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_index_o=0, sp_rd_en_o=0, sp_rd_addr_o=0, sp_rd_target_o=0.
REQ-030 No output SHALL change asynchronously to clk_i on rst_ni.

Verification
REQ-031 Bench with sp model, target 2 rows = 0xA0,0xA1,0xA2,0xA3; start_i cycle 0 target_i=2, m_ready_i=1 -> beats 0xA0..0xA3 cycles 2-5, index 0..3, m_last_o cycle 5 only, done_o cycle 6, busy_o cycles 1-6.
REQ-032 Same, m_ready_i=0 cycles 2-5 -> reads cycles 1,2 only, sp_rd_en_o=0 cycles 3-5, m_data_o=0xA0 stable cycles 2-5; reads resume cycle 6; all four beats in order, no duplicates.
REQ-033 start_i pulsed cycle 3 with target_i=1 during dump of target 2 -> ignored; sp_rd_target_o stays 2; one done_o only.
REQ-034 rst_ni=0 in cycle 3 mid-dump -> cycle 4 all outputs at reset values; new start_i afterwards dumps from address 0.
REQ-035 Back-to-back: start_i in IDLE cycle directly after done_o -> second dump identical timing, targets 0 and 3 each yield their own four rows.
REQ-036 Random m_ready_i toggling, 100 dumps, random targets -> scoreboard matches every row, order, m_last_o, one done_o per dump.

Source files
------------

// File: rtl/sp_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : sp_stream_out
// Purpose  : Dumps every row of one scratchpad target onto a valid/ready
//            output stream.  Reads are issued in address order 0..ENTRIES-1
//            into a 2-entry skid FIFO so the stream never loses or reorders
//            a row under back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module sp_stream_out #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 64,
    parameter int SP_NTARGETS = 4,
    parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    parameter int ENTRIES     = MAX_DIM * MAX_DIM,
    parameter int AW          = 2 * $clog2(MAX_DIM),
    parameter int TW          = $clog2(SP_NTARGETS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [TW-1:0]        target_i,
    output logic                 sp_rd_en_o,
    output logic [TW-1:0]        sp_rd_target_o,
    output logic [AW-1:0]        sp_rd_addr_o,
    input  logic [BUS_WIDTH-1:0] sp_rd_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [BUS_WIDTH-1:0] m_data_o,
    output logic [AW-1:0]        m_index_o,
    output logic                 m_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [1:0]    c_IDLE      = 2'd0;
    localparam logic [1:0]    c_READ      = 2'd1;
    localparam logic [1:0]    c_DRAIN     = 2'd2;
    localparam logic [1:0]    c_DONE      = 2'd3;
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(ENTRIES - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [TW-1:0]        r_target;
    logic [AW-1:0]        r_addr;
    logic [BUS_WIDTH-1:0] r_fifo_data [2];
    logic [AW-1:0]        r_fifo_idx  [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic                 w_fifo_valid;
    logic                 w_push;
    logic                 w_pop;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the last issued read ends READ, an emptied FIFO ends DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_state_nxt = c_READ;
                end
            end
            c_READ: begin
                if (w_push && (r_addr == c_LAST_ADDR)) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs: read strobe gated by FIFO space, stream driven from the FIFO head.
    // A read is allowed into a full FIFO when the head leaves in the same cycle.
    always_comb begin
        w_fifo_valid   = (r_count != 2'd0);
        w_pop          = w_fifo_valid && m_ready_i;
        w_push         = (r_state == c_READ) && ((r_count < 2'd2) || w_pop);

        busy_o         = (r_state != c_IDLE);
        done_o         = (r_state == c_DONE);

        sp_rd_en_o     = w_push;
        sp_rd_target_o = w_push ? r_target : '0;
        sp_rd_addr_o   = w_push ? r_addr   : '0;

        m_valid_o      = w_fifo_valid;
        m_data_o       = w_fifo_valid ? r_fifo_data[r_rd_ptr] : '0;
        m_index_o      = w_fifo_valid ? r_fifo_idx[r_rd_ptr]  : '0;
        m_last_o       = w_fifo_valid && (r_fifo_idx[r_rd_ptr] == c_LAST_ADDR);
    end

    // Datapath: target latch, read address counter and the 2-entry FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_target <= '0;
            r_addr   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_idx[i]  <= '0;
            end
        end else begin
            // Address holds at the last row once it has been read; a new
            // dump always restarts it from zero.
            if ((r_state == c_IDLE) && start_i) begin
                r_target <= target_i;
                r_addr   <= '0;
            end else if (w_push && (r_addr != c_LAST_ADDR)) begin
                r_addr <= r_addr + 1'b1;
            end

            // Read data is valid in the strobe cycle, so it is captured at
            // the edge that closes that cycle, tagged with its row address.
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= sp_rd_data_i;
                r_fifo_idx[r_wr_ptr]  <= r_addr;
                r_wr_ptr              <= ~r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_stream_out
// Purpose  : Self-checking bench for sp_stream_out with a behavioural
//            scratchpad and a cycle-timing / scoreboard reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_stream_out;

    localparam int BW = 64;
    localparam int NE = 4;
    localparam int AW = 2;
    localparam int VW = 7 + 2 * AW + BW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [1:0]    target_i;
    logic          sp_rd_en_o;
    logic [1:0]    sp_rd_target_o;
    logic [AW-1:0] sp_rd_addr_o;
    logic [BW-1:0] sp_rd_data_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [BW-1:0] m_data_o;
    logic [AW-1:0] m_index_o;
    logic          m_last_o;
    logic          busy_o;
    logic          done_o;

    logic [BW-1:0] mem [4][NE];
    logic [VW-1:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    sp_stream_out dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .target_i       (target_i),
        .sp_rd_en_o     (sp_rd_en_o),
        .sp_rd_target_o (sp_rd_target_o),
        .sp_rd_addr_o   (sp_rd_addr_o),
        .sp_rd_data_i   (sp_rd_data_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o),
        .m_index_o      (m_index_o),
        .m_last_o       (m_last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    // Scratchpad model: combinational read in the strobe cycle.
    assign sp_rd_data_i = sp_rd_en_o ? mem[sp_rd_target_o][sp_rd_addr_o] : '0;

    assign obs = {busy_o, done_o, m_valid_o, m_last_o, sp_rd_en_o,
                  sp_rd_target_o, sp_rd_addr_o, m_index_o, m_data_o};

    // Expected outputs r cycles after start for an unstalled dump of target t:
    // reads in cycles 1..NE, beats in 2..NE+1, done in NE+2, busy in 1..NE+2.
    function automatic logic [VW-1:0] nominal(int r, int t);
        logic ev;
        logic er;
        int   bi;
        ev = (r >= 2) && (r <= NE + 1);
        er = (r >= 1) && (r <= NE);
        bi = (r >= 2) ? r - 2 : 0;
        if (bi > NE - 1) bi = NE - 1;
        return {((r >= 1) && (r <= NE + 2)), (r == NE + 2), ev, (r == NE + 1), er,
                (er ? 2'(t) : 2'b00), (er ? AW'(r - 1) : AW'(0)),
                (ev ? AW'(bi) : AW'(0)), (ev ? mem[t][bi] : BW'(0))};
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b1; target_i = 2'd3; m_ready_i = 1'b1;
        @(posedge clk_i); #1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                rst_ni = 1'b1; start_i = 1'b0;
            end
            @(negedge clk_i);
            n_checks++;
            if (obs !== '0) $display("FAIL reset c=%0d got %h exp 0", c, obs);
            else n_pass++;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_basic();
        logic [VW-1:0] e;
        for (int c = 0; c <= 8; c++) begin
            start_i = (c == 0); target_i = 2'd2; m_ready_i = 1'b1;
            @(negedge clk_i);
            e = nominal(c, 2);
            n_checks++;
            if (obs !== e) $display("FAIL basic c=%0d got %h exp %h", c, obs, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
    endtask

    task automatic test_stall();
        logic [VW-1:0] e;
        logic          ev, er;
        int            bi, ea;
        for (int c = 0; c <= 12; c++) begin
            start_i = (c == 0); target_i = 2'd2;
            m_ready_i = !((c >= 2) && (c <= 5));
            @(negedge clk_i);
            // Two reads fill the FIFO, then reads resume once the head moves.
            ev = (c >= 2) && (c <= 9);
            bi = (c <= 6) ? 0 : c - 6;
            er = (c == 1) || (c == 2) || (c == 6) || (c == 7);
            case (c)
                2:       ea = 1;
                6:       ea = 2;
                7:       ea = 3;
                default: ea = 0;
            endcase
            e = {((c >= 1) && (c <= 10)), (c == 10), ev, (ev && (bi == 3)), er,
                 (er ? 2'd2 : 2'd0), AW'(ea), (ev ? AW'(bi) : AW'(0)),
                 (ev ? mem[2][bi] : BW'(0))};
            n_checks++;
            if (obs !== e) $display("FAIL stall c=%0d got %h exp %h", c, obs, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0; m_ready_i = 1'b1;
    endtask

    task automatic test_ignore_start();
        logic [VW-1:0] e;
        for (int c = 0; c <= 9; c++) begin
            start_i  = (c == 0) || (c == 3);
            target_i = (c == 3) ? 2'd1 : 2'd2;
            m_ready_i = 1'b1;
            @(negedge clk_i);
            e = nominal(c, 2);
            n_checks++;
            if (obs !== e) $display("FAIL ignore_start c=%0d got %h exp %h", c, obs, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] e;
        for (int c = 0; c <= 13; c++) begin
            rst_ni   = (c != 3);
            start_i  = (c == 0) || (c == 5);
            target_i = (c < 5) ? 2'd2 : 2'd3;
            m_ready_i = 1'b1;
            @(negedge clk_i);
            if (c <= 3)      e = nominal(c, 2);
            else if (c == 4) e = '0;
            else             e = nominal(c - 5, 3);
            n_checks++;
            if (obs !== e) $display("FAIL reset_mid c=%0d got %h exp %h", c, obs, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        rst_ni = 1'b1; start_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] e;
        for (int c = 0; c <= 14; c++) begin
            start_i  = (c == 0) || (c == 7);
            target_i = (c < 7) ? 2'd0 : 2'd3;
            m_ready_i = 1'b1;
            @(negedge clk_i);
            e = (c < 7) ? nominal(c, 0) : nominal(c - 7, 3);
            n_checks++;
            if (obs !== e) $display("FAIL back_to_back c=%0d got %h exp %h", c, obs, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
    endtask

    task automatic test_random();
        int                 t, beats, dones, cyc;
        logic               stalled;
        logic [BW+AW:0]     held;
        logic [BW+AW:0]     cur;
        logic [BW+AW:0]     expb;
        for (int d = 0; d < 100; d++) begin
            t = $urandom_range(3, 0);
            for (int a = 0; a < NE; a++) mem[t][a] = {$urandom, $urandom};
            beats = 0; dones = 0; cyc = 0; stalled = 1'b0; held = '0;
            start_i = 1'b1; target_i = 2'(t);
            m_ready_i = ($urandom_range(3, 0) != 0);
            while ((dones == 0) && (cyc < 60)) begin
                @(negedge clk_i);
                cur = {m_data_o, m_index_o, m_last_o};
                if (cyc == 0) begin
                    n_checks++;
                    if ({busy_o, done_o} !== 2'b00)
                        $display("FAIL rnd_idle d=%0d got busy=%b done=%b exp 0 0", d, busy_o, done_o);
                    else n_pass++;
                end
                if (stalled) begin
                    n_checks++;
                    if (cur !== held) $display("FAIL rnd_hold d=%0d got %h exp %h", d, cur, held);
                    else n_pass++;
                end
                n_checks++;
                if (sp_rd_en_o) begin
                    if (sp_rd_target_o !== 2'(t))
                        $display("FAIL rnd_rd_target d=%0d got %0d exp %0d", d, sp_rd_target_o, t);
                    else n_pass++;
                end else begin
                    if ({sp_rd_target_o, sp_rd_addr_o} !== '0)
                        $display("FAIL rnd_rd_idle d=%0d got %h exp 0", d, {sp_rd_target_o, sp_rd_addr_o});
                    else n_pass++;
                end
                if (!m_valid_o) begin
                    n_checks++;
                    if (cur !== '0) $display("FAIL rnd_idle_data d=%0d got %h exp 0", d, cur);
                    else n_pass++;
                end
                if (m_valid_o && m_ready_i) begin
                    expb = {mem[t][beats % NE], AW'(beats), (beats == NE - 1)};
                    n_checks++;
                    if (cur !== expb) $display("FAIL rnd_beat d=%0d b=%0d got %h exp %h", d, beats, cur, expb);
                    else n_pass++;
                    beats++;
                end
                stalled = m_valid_o && !m_ready_i;
                held    = cur;
                if (done_o) dones++;
                @(posedge clk_i); #1;
                cyc++;
                // Stray start requests while busy must have no effect.
                start_i   = ($urandom_range(7, 0) == 0);
                target_i  = 2'($urandom_range(3, 0));
                m_ready_i = ($urandom_range(3, 0) != 0);
            end
            n_checks++;
            if (beats != NE) $display("FAIL rnd_beats d=%0d got %0d exp %0d", d, beats, NE);
            else n_pass++;
            n_checks++;
            if (dones != 1) $display("FAIL rnd_done d=%0d got %0d exp 1", d, dones);
            else n_pass++;
        end
        start_i = 1'b0; m_ready_i = 1'b1;
    endtask

    initial begin
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < NE; a++) mem[t][a] = {$urandom, $urandom};
        for (int a = 0; a < NE; a++) mem[2][a] = 64'hA0 + 64'(a);

        test_reset();
        test_basic();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
